// File: rtl/hazard_fetch_ctrl_if.sv
// Fetch/issue bundle: IMEM port, EX branch redirect,
// and the ID-side issue outputs of hazard_fetch_ctrl.
interface hazard_fetch_ctrl_if;
  logic        run;
  logic [15:0] ins;
  logic [15:0] addr;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] ins_id;
  logic        valid_id;
  logic        stall;
  logic        done;
  logic [15:0] stall_cnt;

  modport slave (
    input  run,
    input  ins,
    input  br_taken,
    input  br_target,
    output addr,
    output ins_id,
    output valid_id,
    output stall,
    output done,
    output stall_cnt
  );

  modport master (
    output run,
    output ins,
    output br_taken,
    output br_target,
    input  addr,
    input  ins_id,
    input  valid_id,
    input  stall,
    input  done,
    input  stall_cnt
  );
endinterface

// File: rtl/hazard_fetch_ctrl.sv
// PC owner and IF/ID issue register with a shifting
// destination scoreboard that bubbles RAW hazards.
module hazard_fetch_ctrl #(
  parameter int ROM_DEPTH  = 30,
  parameter int PIPE_DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  hazard_fetch_ctrl_if.slave bus
);
  localparam logic [15:0] RomEnd = 16'(ROM_DEPTH);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_id_q, ins_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic [PIPE_DEPTH-1:0] sb_v_q, sb_v_d;
  logic [2:0] sb_r_q [PIPE_DEPTH];
  logic [2:0] sb_r_d [PIPE_DEPTH];

  logic [4:0] op;
  logic [2:0] rd, rs;
  logic       use_rd, use_rs, wr;
  logic       hit, fetch_act, stall, issue;
  logic       unused_ins;

  assign op = bus.ins[15:11];
  assign rd = bus.ins[10:8];
  assign rs = bus.ins[7:5];
  assign unused_ins = ^bus.ins[4:0];

  always_comb begin
    use_rd = 1'b0;
    use_rs = 1'b0;
    wr     = 1'b0;
    unique case (op)
      5'b00001, 5'b00010: begin
        use_rd = 1'b1;
        use_rs = 1'b1;
        wr     = 1'b1;
      end
      5'b00011: wr = 1'b1;
      5'b00100: begin
        use_rs = 1'b1;
        wr     = 1'b1;
      end
      5'b00101, 5'b00111: begin
        use_rd = 1'b1;
        use_rs = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_v_q[i] &&
          ((use_rd && sb_r_q[i] == rd) ||
           (use_rs && sb_r_q[i] == rs)))
        hit = 1'b1;
    end
  end

  assign fetch_act = bus.run && (pc_q < RomEnd)
                   && !bus.br_taken;
  assign stall = fetch_act && hit;
  assign issue = fetch_act && !hit;

  always_comb begin
    pc_d     = pc_q;
    ins_id_d = 16'h0000;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    sb_v_d   = {sb_v_q[PIPE_DEPTH-2:0], 1'b0};
    sb_r_d[0] = rd;
    for (int i = 1; i < PIPE_DEPTH; i++)
      sb_r_d[i] = sb_r_q[i-1];

    // Branch only redirects; the delay-slot entry keeps shifting.
    if (bus.br_taken) begin
      pc_d = bus.br_target;
    end else if (issue) begin
      pc_d      = pc_q + 16'd1;
      ins_id_d  = bus.ins;
      valid_d   = 1'b1;
      sb_v_d[0] = wr;
    end

    if (stall && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;

    done_d = (pc_d >= RomEnd) && (sb_v_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q     <= 16'h0000;
      ins_id_q <= 16'h0000;
      valid_q  <= 1'b0;
      cnt_q    <= 16'h0000;
      done_q   <= 1'b0;
      sb_v_q   <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++)
        sb_r_q[i] <= 3'd0;
    end else begin
      pc_q     <= pc_d;
      ins_id_q <= ins_id_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      sb_v_q   <= sb_v_d;
      for (int i = 0; i < PIPE_DEPTH; i++)
        sb_r_q[i] <= sb_r_d[i];
    end
  end

  assign bus.addr      = pc_q;
  assign bus.ins_id    = ins_id_q;
  assign bus.valid_id  = valid_q;
  assign bus.stall     = stall;
  assign bus.done      = done_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_fetch_ctrl.sv
// Directed vector bench for hazard_fetch_ctrl with a
// combinational IMEM model indexed by Addr.
module tb_hazard_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_fetch_ctrl_if bus();

  hazard_fetch_ctrl #(
    .ROM_DEPTH(30),
    .PIPE_DEPTH(3)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );

  logic [15:0] rom [64];
  assign bus.ins = (bus.addr < 16'd64)
                 ? rom[bus.addr[5:0]] : 16'h0000;

  typedef struct {
    bit          rst;
    bit          run;
    bit          br;
    logic [15:0] tgt;
    logic [15:0] e_addr;
    bit          e_stall;
    logic [15:0] e_ins;
    bit          e_valid;
    logic [15:0] e_cnt;
    bit          e_done;
  } vec_t;

  vec_t q[$];
  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(
    bit rst, bit run, bit br, logic [15:0] tgt,
    logic [15:0] a, bit s, logic [15:0] ins,
    bit v, logic [15:0] c, bit d);
    vec_t x;
    x.rst = rst; x.run = run; x.br = br; x.tgt = tgt;
    x.e_addr = a; x.e_stall = s; x.e_ins = ins;
    x.e_valid = v; x.e_cnt = c; x.e_done = d;
    q.push_back(x);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 16'h0000;
    @(posedge clk);
    #1;
    chk({tag, " rst addr"}, bus.addr, 16'h0000);
    chk({tag, " rst ins_id"}, bus.ins_id, 16'h0000);
    chk({tag, " rst valid"}, 16'(bus.valid_id), 16'h0);
    chk({tag, " rst cnt"}, bus.stall_cnt, 16'h0000);
    chk({tag, " rst done"}, 16'(bus.done), 16'h0);
  endtask

  task automatic run_vecs(input string tag);
    string nm;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      rst_n = !q[k].rst;
      bus.run = q[k].run;
      bus.br_taken = q[k].br;
      bus.br_target = q[k].tgt;
      #1;
      nm = $sformatf("%s[%0d]", tag, k);
      chk({nm, " addr"}, bus.addr, q[k].e_addr);
      chk({nm, " stall"}, 16'(bus.stall),
          16'(q[k].e_stall));
      @(posedge clk);
      #1;
      chk({nm, " ins_id"}, bus.ins_id, q[k].e_ins);
      chk({nm, " valid"}, 16'(bus.valid_id),
          16'(q[k].e_valid));
      chk({nm, " cnt"}, bus.stall_cnt, q[k].e_cnt);
      chk({nm, " done"}, 16'(bus.done),
          16'(q[k].e_done));
    end
    q.delete();
  endtask

  initial begin
    bus.run = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = 16'h0000;

    // MOVI R0,10 then dependent ADD R0,R1
    clear_rom();
    rom[0] = 16'h180A;
    rom[1] = 16'h0820;
    do_reset("raw");
    add(0, 1, 0, 0, 0, 0, 16'h180A, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 16'h0000, 0, 1, 0);
    add(0, 1, 0, 0, 1, 1, 16'h0000, 0, 2, 0);
    add(0, 1, 0, 0, 1, 1, 16'h0000, 0, 3, 0);
    add(0, 1, 0, 0, 1, 0, 16'h0820, 1, 3, 0);
    add(0, 1, 0, 0, 2, 0, 16'h0000, 1, 3, 0);
    run_vecs("raw");

    clear_rom();
    rom[0] = 16'h1800;
    rom[1] = 16'h1900;
    rom[2] = 16'h1A00;
    do_reset("indep");
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 16'(i), 0, rom[i], 1, 0, 0);
    run_vecs("indep");

    // JMP at 5, delay-slot ADD R5,R2 at 6, word 7 dropped
    clear_rom();
    rom[5]  = 16'h3000;
    rom[6]  = 16'h0D40;
    rom[7]  = 16'h1F00;
    rom[21] = 16'h1921;
    do_reset("br");
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 16'(i), 0, 16'h0000, 1, 0, 0);
    add(0, 1, 0, 0, 5, 0, 16'h3000, 1, 0, 0);
    add(0, 1, 0, 0, 6, 0, 16'h0D40, 1, 0, 0);
    add(0, 1, 1, 21, 7, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 21, 0, 16'h1921, 1, 0, 0);
    add(0, 1, 0, 0, 22, 0, 16'h0000, 1, 0, 0);
    run_vecs("br");

    clear_rom();
    rom[0] = 16'h180A;
    rom[1] = 16'h0820;
    do_reset("brstall");
    add(0, 1, 0, 0, 0, 0, 16'h180A, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 16'h0000, 0, 1, 0);
    add(0, 1, 1, 16, 1, 0, 16'h0000, 0, 1, 0);
    add(0, 1, 0, 0, 16, 0, 16'h0000, 1, 1, 0);
    run_vecs("brstall");

    clear_rom();
    rom[0] = 16'h1B00;
    rom[1] = 16'h0860;
    do_reset("idle");
    add(0, 1, 0, 0, 0, 0, 16'h1B00, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 16'h0860, 1, 0, 0);
    run_vecs("idle");

    // last writer MOVI R4 at word 28, ROM ends at 30
    clear_rom();
    rom[28] = 16'h1C00;
    do_reset("end");
    for (int i = 0; i < 30; i++)
      add(0, 1, 0, 0, 16'(i), 0, rom[i], 1, 0, 0);
    add(0, 1, 0, 0, 30, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 30, 0, 16'h0000, 0, 0, 1);
    add(0, 1, 0, 0, 30, 0, 16'h0000, 0, 0, 1);
    add(0, 1, 1, 5, 30, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 5, 0, 16'h0000, 1, 0, 0);
    run_vecs("end");

    clear_rom();
    rom[0] = 16'h180A;
    rom[1] = 16'h0820;
    do_reset("rststall");
    add(0, 1, 0, 0, 0, 0, 16'h180A, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 16'h0000, 0, 1, 0);
    add(1, 1, 0, 0, 1, 1, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h180A, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 16'h0000, 0, 1, 0);
    add(1, 1, 1, 16, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'h180A, 1, 0, 0);
    run_vecs("rststall");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/hazard_fetch_ctrl.md
Name: hazard_fetch_ctrl

Overview:
- Fetch/issue controller for the 16-bit 5-stage CPU.
- Owns the PC that addresses IMEM and registers the IF/ID instruction.
- Tracks in-flight destination registers in a scoreboard and inserts bubbles on RAW hazards, so programs need no hand-placed NOPs.
- Applies taken branches resolved in EX, with the ISA's one-instruction branch delay slot.

Parameters:
- ROM_DEPTH, 30: number of valid IMEM words. Fetch stops at PC >= ROM_DEPTH.
- PIPE_DEPTH, 3: cycles an issued destination register stays busy (ID→EX→MEM before WB is visible).

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  synchronous active-low reset
- Run  in  1  issue enable; low = hold PC, issue bubbles
- Ins  in  16  instruction from IMEM at Addr (combinational read, same cycle)
- Addr  out  16  PC to IMEM; combinational copy of PC register
- Br_Taken  in  1  taken branch/jump resolved in EX this cycle
- Br_Target  in  16  absolute target PC, valid with Br_Taken
- Ins_ID  out  16  registered instruction issued to ID; 16'h0000 for a bubble
- Valid_ID  out  1  registered; Ins_ID is a real issued instruction
- Stall  out  1  combinational; hazard blocks issue this cycle
- Done  out  1  registered; PC >= ROM_DEPTH and scoreboard empty
- Stall_Cnt  out  16  registered count of hazard-stall cycles, saturating

Behaviour:
- Decode of Ins: op = Ins[15:11], rd = Ins[10:8], rs = Ins[7:5].
  - NOP 00000: no reads, no write.
  - ADD 00001, SUB 00010: read rd, rs; write rd.
  - MOVI 00011: write rd.
  - LODR 00100: read rs; write rd.
  - STO 00101: read rd, rs.
  - JMP 00110: no reads, no write.
  - JEQ 00111: read rd, rs.
  - Other opcodes: treated as NOP, still issued.
- Scoreboard:
  - PIPE_DEPTH slots of {v, reg[2:0]}; shifts one slot per cycle, slot PIPE_DEPTH-1 retires.
  - Slot 0 loads {1, rd} on an issue of a writing instruction, else {0, x}.
- Hazard: Stall = 1 when fetch is active (Run = 1, PC < ROM_DEPTH, Br_Taken = 0) and any valid slot's reg equals an operand Ins reads.
- Priority each cycle:
  1. Br_Taken
  2. Run = 0 or PC >= ROM_DEPTH
  3. Stall
  4. issue
- Br_Taken:
  - PC <= Br_Target. Ins_ID <= 0, Valid_ID <= 0, slot 0 <= invalid.
  - The word currently fetched is discarded.
  - The instruction already in Ins_ID (delay slot) is not flushed; its scoreboard entry keeps shifting.
- Idle (Run = 0 or PC >= ROM_DEPTH): PC holds, bubble issued, scoreboard drains, Stall = 0.
- Stall: PC holds, bubble issued, scoreboard shifts. Stall_Cnt increments, saturating at 16'hFFFF.
- Issue: Ins_ID <= Ins, Valid_ID <= 1, PC <= PC + 1 (16-bit wrap), slot 0 loaded per decode.
- Latency:
  - Ins_ID valid one cycle after Addr presents the word.
  - A dependent instruction issued back-to-back behind a writer sees exactly PIPE_DEPTH stall cycles.
- Done: set when PC >= ROM_DEPTH and all slots invalid. Clears if a branch brings PC back in range.
- Reset (Rst_n = 0 at a rising edge, any state, including mid-stall or with Br_Taken high):
  - PC = 0, Ins_ID = 0, Valid_ID = 0, all slots invalid, Stall_Cnt = 0, Done = 0.
  - Reset overrides Br_Taken.
- R0 is a normal register for hazard purposes (no hardwired zero).

Test Plan:
- Reset then Run = 1, program MOVI R0,10 / ADD R0,R1 at words 0,1 → MOVI issued cycle 1; Stall high 3 cycles; ADD issued cycle 5; Stall_Cnt = 3.
- Independent stream MOVI R0 / MOVI R1 / MOVI R2 → one issue per cycle, PC 0,1,2,3, Stall never high, Stall_Cnt = 0.
- Branch with delay slot: JMP at 5 then ADD R5,R2 at 6; assert Br_Taken with Br_Target = 21 when JMP is in EX → ADD at 6 stays issued, word 7 dropped (bubble), next Addr = 21.
- Br_Taken asserted during a hazard stall → branch wins: Addr = Br_Target next cycle, Valid_ID = 0, no Stall_Cnt increment that cycle.
- Run = 0 for 4 cycles after MOVI R3 issues → PC frozen, 4 bubbles, scoreboard empty afterwards; Run = 1 with ADD R0,R3 → issues immediately, no stall.
- Run to PC = ROM_DEPTH = 30 → bubbles thereafter, Done = 1 three cycles after the last writer issues. Rst_n low one cycle mid-stall → all outputs at reset values, Addr = 0.
